// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: operand forwarding selects, load-use stall and
// branch flush sequencing, plus saturating stall/flush event counters.
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic [3:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        branch_taken,
  input  logic        clr_counts,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall,
  output logic        flush,
  output logic        bubble,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Register 0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic src_match(input logic [3:0] rd, input logic wr, input logic [3:0] src);
    return wr && (rd != 4'd0) && (rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                         input logic [3:0] ex_rd, input logic ex_wr,
                                         input logic [3:0] mem_rd, input logic mem_wr);
    logic [1:0] sel;
    if (src_match(ex_rd, ex_wr, src)) begin
      sel = 2'd2;
    end else if (src_match(mem_rd, mem_wr, src)) begin
      sel = 2'd1;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    logic [15:0] res;
    if (en && (cnt != 16'hFFFF)) begin
      res = cnt + 16'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  ex_rd_r;
  logic        ex_wr_r;
  logic        ex_ld_r;
  logic [3:0]  mem_rd_r;
  logic        mem_wr_r;
  logic [1:0]  forward_a_r;
  logic [1:0]  forward_b_r;
  logic [15:0] stall_count_r;
  logic [15:0] flush_count_r;
  logic        load_use_s;
  logic        stall_s;
  logic        flush_s;
  logic        bubble_s;

  // Load-use hazard: decode reads a register the execute-stage load has not produced yet.
  always_comb begin
    load_use_s = id_valid && ex_ld_r && (ex_rd_r != 4'd0) &&
                 ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2));
  end

  // Next-state and pipeline control; a taken branch outranks a load-use stall.
  always_comb begin
    state_nxt_s = ST_RUN;
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    bubble_s    = 1'b0;
    if (rst) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (branch_taken) begin
            flush_s     = 1'b1;
            bubble_s    = 1'b1;
            state_nxt_s = ST_FLUSH;
          end else if (load_use_s) begin
            stall_s     = 1'b1;
            bubble_s    = 1'b1;
            state_nxt_s = ST_STALL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_STALL: state_nxt_s = ST_RUN;
        ST_FLUSH: state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_RUN;
      endcase
    end
  end

  // State register, execute/memory shadow registers and forwarding selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      ex_rd_r     <= 4'd0;
      ex_wr_r     <= 1'b0;
      ex_ld_r     <= 1'b0;
      mem_rd_r    <= 4'd0;
      mem_wr_r    <= 1'b0;
      forward_a_r <= 2'd0;
      forward_b_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      mem_rd_r <= ex_rd_r;
      mem_wr_r <= ex_wr_r;
      if (bubble_s) begin
        ex_rd_r     <= 4'd0;
        ex_wr_r     <= 1'b0;
        ex_ld_r     <= 1'b0;
        forward_a_r <= 2'd0;
        forward_b_r <= 2'd0;
      end else begin
        ex_rd_r     <= id_rd;
        ex_wr_r     <= id_regwrite & id_valid;
        ex_ld_r     <= id_is_load & id_valid;
        forward_a_r <= fwd_sel(id_rs1, ex_rd_r, ex_wr_r, mem_rd_r, mem_wr_r);
        forward_b_r <= fwd_sel(id_rs2, ex_rd_r, ex_wr_r, mem_rd_r, mem_wr_r);
      end
    end
  end

  // Saturating event counters; clearing wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_r <= 16'd0;
      flush_count_r <= 16'd0;
    end else if (clr_counts) begin
      stall_count_r <= 16'd0;
      flush_count_r <= 16'd0;
    end else begin
      stall_count_r <= sat_inc(stall_count_r, stall_s);
      flush_count_r <= sat_inc(flush_count_r, flush_s);
    end
  end

  assign forward_a   = forward_a_r;
  assign forward_b   = forward_b_r;
  assign stall       = stall_s;
  assign flush       = flush_s;
  assign bubble      = bubble_s;
  assign state       = state_r;
  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The module SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port `rst`: input, 1 bit, asynchronous, active-high reset.
REQ-003 The module SHALL have the port `id_valid`: input, 1 bit, the decode slot holds a real instruction.
REQ-004 The module SHALL have the ports `id_rs1`, `id_rs2`: input, 4 bits each, the source registers of the decode instruction.
REQ-005 The module SHALL have the port `id_rd`: input, 4 bits, the destination register of the decode instruction.
REQ-006 The module SHALL have the port `id_regwrite`: input, 1 bit, the decode instruction writes `id_rd`.
REQ-007 The module SHALL have the port `id_is_load`: input, 1 bit, the decode instruction is a memory load.
REQ-008 The module SHALL have the port `branch_taken`: input, 1 bit, the execute-stage branch resolved taken this cycle.
REQ-009 The module SHALL have the port `clr_counts`: input, 1 bit, synchronous clear of both counters.
REQ-010 The module SHALL have the ports `forward_a`, `forward_b`: output, 2 bits each, registered execute-operand selects (0 = register file, 1 = writeback result, 2 = memory-stage result, 3 = never driven).
REQ-011 The module SHALL have the port `stall`: output, 1 bit, combinational, hold PC and IF/ID this cycle.
REQ-012 The module SHALL have the port `flush`: output, 1 bit, combinational, clear IF/ID this cycle.
REQ-013 The module SHALL have the port `bubble`: output, 1 bit, combinational, ID/EX loads a NOP this cycle.
REQ-014 The module SHALL have the port `state`: output, 2 bits, FSM state (0 RUN, 1 STALL, 2 FLUSH).
REQ-015 The module SHALL have the ports `stall_count`, `flush_count`: output, 16 bits each, saturating event counters.

Function
REQ-016 The module SHALL keep shadow registers ex_{rd,wr,ld} and mem_{rd,wr}, which track the execute-stage and memory-stage instructions.
REQ-017 On every non-reset edge: mem <= ex; ex <= 0 if `bubble`, else {`id_rd`, `id_regwrite`&`id_valid`, `id_is_load`&`id_valid`}.
REQ-018 A match for source s SHALL require: wr=1, rd==s and rd!=0; register 0 is never forwarded.
REQ-019 On each edge, `forward_a` <= 2 if ex matches `id_rs1`, else 1 if mem matches `id_rs1`, else 0; the ex (newer) producer SHALL win.
REQ-020 `forward_b` SHALL follow the same rule as REQ-019 with `id_rs2`.
REQ-021 Both forward registers SHALL load 0 on any edge where `bubble`=1.
REQ-022 A load-use hazard SHALL be defined as: `id_valid`=1, ex_ld=1, ex_rd!=0, and ex_rd equal to `id_rs1` or `id_rs2`.
REQ-023 In RUN with `branch_taken`=1: `flush`=1, `bubble`=1, `stall`=0, and the next state is FLUSH.
REQ-024 In RUN with no branch and a load-use hazard: `stall`=1, `bubble`=1, and the next state is STALL.
REQ-025 In RUN with neither condition: `stall`, `flush` and `bubble` SHALL all be 0, and the state stays RUN.
REQ-026 STALL SHALL last exactly 1 cycle, with outputs 0 and next state RUN; the held instruction then sees the load in mem and gets forward=1.
REQ-027 In STALL, `branch_taken` SHALL be ignored, because a bubble occupies execute.
REQ-028 FLUSH SHALL last exactly 1 cycle, with outputs 0 and `branch_taken` ignored; the next state is RUN and the decode instruction advances normally.
REQ-029 When a branch and a hazard occur simultaneously, the branch SHALL win: no stall, and `stall_count` does not increment.
REQ-030 `stall_count` SHALL increment on each edge where `stall`=1 and saturate at 16'hFFFF.
REQ-031 `flush_count` SHALL increment on each edge where `flush`=1 and saturate at 16'hFFFF.
REQ-032 `clr_counts` SHALL take priority over increment, setting both counters to 0 on the edge.
REQ-033 Latency: `stall`, `flush` and `bubble` SHALL be 0-cycle combinational; `forward_a` and `forward_b` SHALL be valid the cycle after the instruction leaves decode.

Reset
REQ-034 While `rst`=1 (asynchronously), the state SHALL be RUN and all shadow registers, `forward_a`, `forward_b`, `stall_count` and `flush_count` SHALL be 0.
REQ-035 While `rst`=1, `stall`, `flush` and `bubble` SHALL be forced to 0.
REQ-036 Reset asserted mid-STALL or mid-FLUSH SHALL abandon the state immediately; the first post-reset cycle is RUN with no pending hazard.

Verification
REQ-037 Scenario: ADD r3 (`id_rd`=3, `id_regwrite`=1) then consumer `id_rs1`=3 -> `forward_a`=2 next cycle, `stall`=0.
REQ-038 Scenario: producer rd=3, an unrelated instruction, then consumer `id_rs2`=3 -> `forward_b`=1; producer rd=0 -> forward 0.
REQ-039 Scenario: load rd=5 followed by `id_rs1`=5 -> `stall`=1 and `bubble`=1 for one cycle, `state`=1, then `forward_a`=1, `stall_count`=1.
REQ-040 Scenario: `branch_taken`=1 coincident with a load-use hazard -> `flush`=1, `stall`=0, `state`=2 next, `flush_count`=1, `stall_count` unchanged.
REQ-041 Scenario: `stall_count` preloaded to FFFF by repeated hazards, then another hazard -> stays FFFF; `clr_counts` -> 0.
REQ-042 Scenario: `rst` pulsed during STALL -> all outputs 0 immediately and `state`=0; a following independent instruction has no stall.
